regbank_arbiter: RTL and testbench
==================================

# regbank_arbiter

Two-port arbiter and sequencer for the UART data register bank. Serializes read/write requests from two masters (port 0: UART RX/TX engine, port 1: host/control logic) onto the bank's single access port using round-robin priority and a req/done handshake. Registered read data is returned to the winning requester. It sits between the requesters and the register bank.

## Interface
Parameters:
- AW, 8, bank address width (2**AW entries)
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- hold  in  1  when high, no new grant is issued; an access in flight completes
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  bank address
- wdata0 / wdata1  in  DW  write data
- done0 / done1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data, valid while the matching doneN is high
- gnt  out  2  one-hot owner of the bank, from ISSUE through DONE; 0 otherwise
- busy  out  1  FSM not in IDLE
- bank_en  out  1  bank access strobe
- bank_we  out  1  bank write enable, qualified by bank_en
- bank_addr  out  AW  bank address
- bank_wdata  out  DW  bank write data
- bank_rdata  in  DW  bank read data, valid one cycle after a bank_en read

## Operation
- FSM states: IDLE, ISSUE, CAPT, DONE.
- IDLE: if !hold and (req0|req1), pick the winner and latch its we/addr/wdata. Next state is ISSUE. Otherwise stay in IDLE.
- Round-robin rule: a single requester wins. If both request, the port not served last wins. The last-served pointer resets to port 1, so port 0 wins the first tie.
- ISSUE: bank_en=1, with bank_we/addr/wdata driven from the latched values. A write goes to DONE; a read goes to CAPT.
- CAPT: bank_rdata is registered into the winner's rdataN. Next state is DONE.
- DONE: doneN=1 for the winner, and the last-served pointer updates. Next state is IDLE.
- Requester rule: req/we/addr/wdata are held stable from assertion until done is seen. req is dropped on the edge that samples done, otherwise it is treated as a new request.
- Request fields are latched in IDLE; later changes do not affect the access in flight.
- rdataN holds its last value until the next read completes on that port. Writes do not change rdata.
- hold only blocks the IDLE→ISSUE transition. It has no effect in other states.
- Reset mid-operation: return to IDLE with no done pulse and no bank_en. Pointer returns to port 1.

## Timing
- Reset values: done0=done1=0, rdata0=rdata1=0, gnt=0, busy=0, bank_en=0, bank_we=0, bank_addr=0, bank_wdata=0.
- All outputs are registered or decoded from the state register only; there is no combinational path from req to any output.
- Write latency: req sampled in IDLE at edge T → bank_en cycle T+1 → done cycle T+2.
- Read latency: req sampled at T → bank_en cycle T+1 → capture cycle T+2 → done and rdata cycle T+3.
- Throughput: one write per 3 cycles, one read per 4 cycles, because IDLE is always visited between accesses.
- Starvation: with both ports requesting continuously, grants strictly alternate.

## Structure
- Package regbank_arb_pkg holds:
  - state typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE}
  - NUM_PORTS = 2
  - port-index typedef
- Sub-module rr_arbiter2: combinational two-way round-robin pick from {req1,req0} and the last-served pointer. The pointer register lives in regbank_arbiter.
- Top level holds the FSM, request latch, rdata registers and output decode.

## Test plan
- Port 0 write, addr=0x05, wdata=0xDEADBEEF, req at T → bank_en=1, bank_we=1 with that addr/data at T+1; done0 at T+2; gnt=01 during T+1..T+2.
- Port 1 read of addr=0x05 after the write above, bank model with 1-cycle latency → done1 at T+3 with rdata1=0xDEADBEEF; rdata0 unchanged.
- req0 and req1 asserted together and held, re-requesting after each done → grant order 0,1,0,1; no port gets two consecutive grants.
- hold=1 with req0=1 for 10 cycles → busy=0, bank_en never asserted. Release hold → bank_en on the cycle after the first IDLE sample.
- rst asserted on a read's CAPT cycle → next cycle IDLE, busy=0, no done0/done1 pulse, rdata0=0. Then a simultaneous req0/req1 → port 0 wins.
- Port 0 changes addr0 during ISSUE → bank_addr keeps the originally latched address for the whole access.

Source files
------------

// File: rtl/regbank_arb_pkg.sv
// Shared types and constants for the UART data register bank arbiter.
package regbank_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the port not served last wins.
module rr_arbiter2
  import regbank_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_idx_t  last_i,
  output logic       valid_o,
  output port_idx_t  win_o
);

  always_comb begin
    valid_o = |req_i;
    win_o   = port_idx_t'(0);
    if (req_i == 2'b11) begin
      win_o = ~last_i;
    end else if (req_i[1]) begin
      win_o = port_idx_t'(1);
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Serializes two masters onto the register bank's single access port and returns
// registered read data to the winning requester.
module regbank_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          bank_en,
  output logic          bank_we,
  output logic [AW-1:0] bank_addr,
  output logic [DW-1:0] bank_wdata,
  input  logic [DW-1:0] bank_rdata,
  output state_t        state_dbg
);

  // Handshake: a master raises reqN with we/addr/wdata stable and keeps them until it
  // sees doneN high; it drops reqN on the edge that samples doneN, or it re-requests.

  state_t          state_q, state_d;
  port_idx_t       last_q;
  port_idx_t       win_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata0_q, rdata1_q;
  logic            arb_valid;
  port_idx_t       arb_win;
  logic            accept;

  rr_arbiter2 u_rr (
    .req_i   ({req1, req0}),
    .last_i  (last_q),
    .valid_o (arb_valid),
    .win_o   (arb_win)
  );

  assign accept = (state_q == IDLE) && !hold && arb_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = we_q ? DONE : CAPT;
      CAPT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE so the master may change them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= port_idx_t'(0);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      win_q   <= arb_win;
      we_q    <= arb_win[0] ? we1    : we0;
      addr_q  <= arb_win[0] ? addr1  : addr0;
      wdata_q <= arb_win[0] ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= port_idx_t'(1);
    end else if (state_q == DONE) begin
      last_q <= win_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == CAPT) begin
      if (win_q[0]) rdata1_q <= bank_rdata;
      else          rdata0_q <= bank_rdata;
    end
  end

  always_comb begin
    gnt        = 2'b00;
    busy       = (state_q != IDLE);
    bank_en    = (state_q == ISSUE);
    bank_we    = (state_q == ISSUE) && we_q;
    bank_addr  = addr_q;
    bank_wdata = wdata_q;
    done0      = (state_q == DONE) && !win_q[0];
    done1      = (state_q == DONE) &&  win_q[0];
    rdata0     = rdata0_q;
    rdata1     = rdata1_q;
    state_dbg  = state_q;
    if (state_q != IDLE) gnt[win_q] = 1'b1;
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: single-cycle-latency bank model plus
// hand-computed checks on latency, round-robin order, hold and mid-access reset.
module tb_regbank_arbiter;
  import regbank_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, hold;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1;
  logic [DW-1:0] rdata0, rdata1;
  logic [1:0]    gnt;
  logic          busy, bank_en, bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] bank_rdata;
  state_t        state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [2**AW];

  regbank_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .gnt(gnt), .busy(busy), .bank_en(bank_en), .bank_we(bank_we),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Bank model: writes on the strobe edge, read data valid the cycle after.
  always @(posedge clk) begin
    if (bank_en) begin
      if (bank_we) mem[bank_addr] <= bank_wdata;
      else         bank_rdata <= mem[bank_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_order [4];
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    bank_rdata = '0;
    rst = 1'b1; hold = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step(); step();

    // Reset values
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bank_en", 32'(bank_en), 32'h0);
    check("rst_bank_we", 32'(bank_we), 32'h0);
    check("rst_bank_addr", 32'(bank_addr), 32'h0);
    check("rst_bank_wdata", bank_wdata, 32'h0);
    check("rst_done", {30'd0, done1, done0}, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    rst = 1'b0;
    step();

    // Port 0 write: bank_en at T+1, done0 at T+2
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h05; wdata0 = 32'hDEADBEEF;
    step();
    check("wr_bank_en", 32'(bank_en), 32'h1);
    check("wr_bank_we", 32'(bank_we), 32'h1);
    check("wr_bank_addr", 32'(bank_addr), 32'h05);
    check("wr_bank_wdata", bank_wdata, 32'hDEADBEEF);
    check("wr_gnt_issue", 32'(gnt), 32'h1);
    check("wr_done0_early", 32'(done0), 32'h0);
    step();
    check("wr_done0", 32'(done0), 32'h1);
    check("wr_gnt_done", 32'(gnt), 32'h1);
    check("wr_bank_en_off", 32'(bank_en), 32'h0);
    req0 = 1'b0;
    step();
    check("wr_idle_busy", 32'(busy), 32'h0);
    check("wr_idle_done0", 32'(done0), 32'h0);

    // Port 1 read of 0x05: done1 at T+3 with the written data
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
    step();
    check("rd_bank_en", 32'(bank_en), 32'h1);
    check("rd_bank_we", 32'(bank_we), 32'h0);
    check("rd_gnt", 32'(gnt), 32'h2);
    step();
    check("rd_capt_done1", 32'(done1), 32'h0);
    check("rd_capt_gnt", 32'(gnt), 32'h2);
    check("rd_capt_bank_en", 32'(bank_en), 32'h0);
    step();
    check("rd_done1", 32'(done1), 32'h1);
    check("rd_rdata1", rdata1, 32'hDEADBEEF);
    check("rd_rdata0_kept", rdata0, 32'h0);
    req1 = 1'b0;
    step();

    // Both ports hold their requests: grants alternate starting with port 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'h11111111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 32'h22222222;
    for (int g = 0; g < 4; g++) begin
      step();
      check($sformatf("rr_gnt_%0d", g), 32'(gnt), 32'(exp_order[g]));
      step();
      check($sformatf("rr_done_%0d", g), {30'd0, done1, done0}, 32'(exp_order[g]));
      step();
      check($sformatf("rr_idle_%0d", g), 32'(busy), 32'h0);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // hold blocks the grant; release gives bank_en on the next cycle
    hold = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("hold_busy_%0d", c), 32'(busy), 32'h0);
      check($sformatf("hold_bank_en_%0d", c), 32'(bank_en), 32'h0);
    end
    hold = 1'b0;
    step();
    check("hold_rel_bank_en", 32'(bank_en), 32'h1);
    check("hold_rel_bank_addr", 32'(bank_addr), 32'h20);
    step();
    step();
    check("hold_rd_done0", 32'(done0), 32'h1);
    check("hold_rd_rdata0", rdata0, 32'h22222222);
    req0 = 1'b0;
    step();

    // Reset during a read's capture cycle
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    step();
    check("rst_mid_issue", 32'(state_dbg), 32'(ISSUE));
    step();
    check("rst_mid_capt", 32'(state_dbg), 32'(CAPT));
    rst = 1'b1; req0 = 1'b0;
    step();
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_done", {30'd0, done1, done0}, 32'h0);
    check("rst_mid_rdata0", rdata0, 32'h0);
    check("rst_mid_bank_en", 32'(bank_en), 32'h0);
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 32'h33333333;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h31; wdata1 = 32'h44444444;
    step();
    check("rst_tie_gnt", 32'(gnt), 32'h1);
    step();
    check("rst_tie_done0", 32'(done0), 32'h1);
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Address change after latching does not affect the access
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    step();
    check("lat_addr_issue", 32'(bank_addr), 32'h05);
    addr0 = 8'h3F;
    step();
    check("lat_addr_capt", 32'(bank_addr), 32'h05);
    step();
    check("lat_addr_done", 32'(bank_addr), 32'h05);
    check("lat_done0", 32'(done0), 32'h1);
    check("lat_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 1'b0;
    step();
    check("lat_final_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
